// File: rtl/fifo_stream_param.sv
// Parametrised valid/ready stream FIFO: first-word fall-through, level, almost flags, sync flush.
// Optional statistics counters (push/pop/stall) are enabled by defining FIFO_STREAM_STATS_EN.
module fifo_stream_param #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int AF_MARGIN  = 2,
  parameter int AE_MARGIN  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     val_in,
  output logic                     ready_upward,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     val_out,
  input  logic                     ready_downward,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty
`ifdef FIFO_STREAM_STATS_EN
  ,
  output logic [31:0]              push_cnt,
  output logic [31:0]              pop_cnt,
  output logic [31:0]              stall_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(DEPTH - AF_MARGIN);
  localparam logic [LW-1:0] AE_LVL   = LW'(AE_MARGIN);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push, pop;

  // Acceptance never looks at ready_downward, so a full FIFO refuses even while popping.
  assign ready_upward = ~flush & (level_q != FULL_LVL);
  assign val_out      = (level_q != '0);
  assign push         = val_in & ready_upward;
  assign pop          = val_out & ready_downward & ~flush;

  assign dout         = mem[rd_ptr_q];
  assign level        = level_q;
  assign almost_full  = (level_q >= AF_LVL);
  assign almost_empty = (level_q <= AE_LVL);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left unreset; level gates whether dout means anything.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end

`ifdef FIFO_STREAM_STATS_EN
  logic [31:0] push_cnt_q, push_cnt_d;
  logic [31:0] pop_cnt_q, pop_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    push_cnt_d  = push_cnt_q + 32'(push);
    pop_cnt_d   = pop_cnt_q + 32'(pop);
    stall_cnt_d = stall_cnt_q + 32'(val_out & ~ready_downward);
  end

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      push_cnt_q  <= '0;
      pop_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      push_cnt_q  <= push_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign push_cnt  = push_cnt_q;
  assign pop_cnt   = pop_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_stream_param.sv
// Directed bench for fifo_stream_param (DEPTH=8): fill, full-pop, streaming, random scoreboard, flush.
// Statistics counters are checked when FIFO_STREAM_STATS_EN is defined.
module tb_fifo_stream_param;

  logic        clk = 1'b0;
  logic        reset, flush, val_in, ready_upward, val_out, ready_downward;
  logic        almost_full, almost_empty;
  logic [31:0] din, dout;
  logic [3:0]  level;
`ifdef FIFO_STREAM_STATS_EN
  logic [31:0] push_cnt, pop_cnt, stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_stream_param #(.DATA_WIDTH(32), .DEPTH(8), .AF_MARGIN(2), .AE_MARGIN(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .din(din), .val_in(val_in), .ready_upward(ready_upward),
    .dout(dout), .val_out(val_out), .ready_downward(ready_downward),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
`ifdef FIFO_STREAM_STATS_EN
    , .push_cnt(push_cnt), .pop_cnt(pop_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // Every step sets inputs right after a falling edge and samples #1 later.
  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; val_in = 1'b0; ready_downward = 1'b0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (val_out !== 1'b0) begin n_fail++; $display("FAIL reset_val_out got %b want 0", val_out); end
    n_checks++; if (ready_upward !== 1'b1) begin n_fail++; $display("FAIL reset_ready_up got %b want 1", ready_upward); end
    n_checks++; if (almost_empty !== 1'b1) begin n_fail++; $display("FAIL reset_ae got %b want 1", almost_empty); end
    n_checks++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", almost_full); end
    $display("test_reset done: level=%0d val_out=%b ready_up=%b", level, val_out, ready_upward);
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      val_in = 1'b1; din = 32'h11 * (i + 1); ready_downward = 1'b0;
      #1;
      n_checks++; if (ready_upward !== 1'b1) begin n_fail++; $display("FAIL fill_ready_up[%0d] got %b want 1", i, ready_upward); end
      @(negedge clk);
      n_checks++; if (level !== 4'(i + 1)) begin n_fail++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, i + 1); end
      n_checks++; if (almost_full !== (i + 1 >= 6)) begin n_fail++; $display("FAIL fill_af[%0d] got %b want %b", i, almost_full, (i + 1 >= 6)); end
      n_checks++; if (almost_empty !== (i + 1 <= 2)) begin n_fail++; $display("FAIL fill_ae[%0d] got %b want %b", i, almost_empty, (i + 1 <= 2)); end
      n_checks++; if (dout !== 32'h11) begin n_fail++; $display("FAIL fill_head[%0d] got %h want 00000011", i, dout); end
      $display("fill push %h -> level %0d af=%b", din, level, almost_full);
    end
    din = 32'h99; val_in = 1'b1;
    #1;
    n_checks++; if (ready_upward !== 1'b0) begin n_fail++; $display("FAIL full_ready_up got %b want 0", ready_upward); end
    @(negedge clk);
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL refused_level got %0d want 8", level); end
    n_checks++; if (dout !== 32'h11) begin n_fail++; $display("FAIL refused_head got %h want 00000011", dout); end
    $display("9th word refused: level %0d", level);
  endtask

  task automatic test_full_pop();
    logic [31:0] exp;
    val_in = 1'b1; din = 32'h99; ready_downward = 1'b1;
    #1;
    n_checks++; if (ready_upward !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready_up got %b want 0", ready_upward); end
    n_checks++; if (dout !== 32'h11) begin n_fail++; $display("FAIL fullpop_head got %h want 00000011", dout); end
    @(negedge clk);
    n_checks++; if (level !== 4'd7) begin n_fail++; $display("FAIL fullpop_level got %0d want 7", level); end
    n_checks++; if (dout !== 32'h22) begin n_fail++; $display("FAIL fullpop_next got %h want 00000022", dout); end
    ready_downward = 1'b0;
    #1;
    n_checks++; if (ready_upward !== 1'b1) begin n_fail++; $display("FAIL refill_ready_up got %b want 1", ready_upward); end
    @(negedge clk);
    n_checks++; if (level !== 4'd8) begin n_fail++; $display("FAIL refill_level got %0d want 8", level); end
    $display("full pop+push: popped 11, 99 accepted next cycle, level %0d", level);
    val_in = 1'b0; ready_downward = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp = (k < 7) ? 32'h11 * (k + 2) : 32'h99;
      #1;
      n_checks++; if (val_out !== 1'b1 || dout !== exp) begin n_fail++; $display("FAIL drain[%0d] got %b/%h want 1/%h", k, val_out, dout, exp); end
      $display("drain pop %h", dout);
      @(negedge clk);
    end
    ready_downward = 1'b0;
    #1;
    n_checks++; if (level !== 4'd0 || val_out !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %0d/%b want 0/0", level, val_out); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 100; k++) begin
      val_in = 1'b1; ready_downward = 1'b1; din = 32'h100 + k;
      #1;
      if (k > 0) begin
        n_checks++; if (val_out !== 1'b1 || dout !== 32'h100 + k - 1) begin n_fail++; $display("FAIL stream[%0d] got %b/%h want 1/%h", k, val_out, dout, 32'h100 + k - 1); end
      end
      @(negedge clk);
      n_checks++; if (level !== 4'd1) begin n_fail++; $display("FAIL stream_level[%0d] got %0d want 1", k, level); end
    end
    val_in = 1'b0;
    #1;
    n_checks++; if (dout !== 32'h163) begin n_fail++; $display("FAIL stream_last got %h want 00000163", dout); end
    @(negedge clk);
    ready_downward = 1'b0;
    #1;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL stream_end_level got %0d want 0", level); end
    $display("stream of 100 words done, level %0d", level);
  endtask

  task automatic test_random();
    logic [31:0] q[$];
    logic        do_push, do_pop;
    int          errs_before;
    errs_before = n_fail;
    for (int c = 0; c < 10000; c++) begin
      val_in = ($urandom_range(0, 3) != 0);
      ready_downward = ($urandom_range(0, 1) == 1);
      din = $urandom;
      #1;
      n_checks++; if (level !== 4'(q.size())) begin n_fail++; $display("FAIL rand_level[%0d] got %0d want %0d", c, level, q.size()); end
      n_checks++; if (val_out !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_val_out[%0d] got %b want %b", c, val_out, q.size() != 0); end
      n_checks++; if (ready_upward !== (q.size() != 8)) begin n_fail++; $display("FAIL rand_ready_up[%0d] got %b want %b", c, ready_upward, q.size() != 8); end
      if (q.size() > 0) begin
        n_checks++; if (dout !== q[0]) begin n_fail++; $display("FAIL rand_dout[%0d] got %h want %h", c, dout, q[0]); end
      end
      do_push = val_in && (q.size() < 8);
      do_pop  = ready_downward && (q.size() > 0);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(din);
      @(negedge clk);
    end
    val_in = 1'b0; ready_downward = 1'b1;
    for (int k = 0; k < 8 && q.size() > 0; k++) begin
      #1;
      n_checks++; if (dout !== q[0]) begin n_fail++; $display("FAIL rand_drain[%0d] got %h want %h", k, dout, q[0]); end
      void'(q.pop_front());
      @(negedge clk);
    end
    ready_downward = 1'b0;
    #1;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL rand_end_level got %0d want 0", level); end
    $display("random 10000 cycles done, new failures %0d", n_fail - errs_before);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      val_in = 1'b1; ready_downward = 1'b0; din = 32'h200 + i;
      @(negedge clk);
    end
    #1;
    n_checks++; if (level !== 4'd5) begin n_fail++; $display("FAIL flush_pre_level got %0d want 5", level); end
    flush = 1'b1; val_in = 1'b1; ready_downward = 1'b1; din = 32'hAA;
    #1;
    n_checks++; if (ready_upward !== 1'b0) begin n_fail++; $display("FAIL flush_ready_up got %b want 0", ready_upward); end
    @(negedge clk);
    flush = 1'b0; val_in = 1'b0; ready_downward = 1'b0;
    #1;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL flush_level got %0d want 0", level); end
    n_checks++; if (val_out !== 1'b0) begin n_fail++; $display("FAIL flush_val_out got %b want 0", val_out); end
    n_checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin n_fail++; $display("FAIL flush_flags got ae=%b af=%b want 1/0", almost_empty, almost_full); end
    val_in = 1'b1; din = 32'hBB;
    @(negedge clk);
    val_in = 1'b0;
    #1;
    n_checks++; if (level !== 4'd1 || dout !== 32'hBB) begin n_fail++; $display("FAIL post_flush got %0d/%h want 1/000000bb", level, dout); end
    ready_downward = 1'b1;
    @(negedge clk);
    ready_downward = 1'b0;
    #1;
    n_checks++; if (level !== 4'd0) begin n_fail++; $display("FAIL post_flush_drain got %0d want 0", level); end
    $display("flush at level 5 discarded contents and in-flight transfers");
  endtask

`ifdef FIFO_STREAM_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++; if (push_cnt !== 0 || pop_cnt !== 0 || stall_cnt !== 0) begin n_fail++; $display("FAIL stats_reset got %0d/%0d/%0d want 0/0/0", push_cnt, pop_cnt, stall_cnt); end
    for (int i = 0; i < 20; i++) begin
      val_in = 1'b1; ready_downward = 1'b1; din = 32'h300 + i;
      @(negedge clk);
    end
    val_in = 1'b0; ready_downward = 1'b0;
    repeat (7) @(negedge clk);
    ready_downward = 1'b1;
    @(negedge clk);
    ready_downward = 1'b0;
    #1;
    n_checks++; if (push_cnt !== 32'd20 || pop_cnt !== 32'd20 || stall_cnt !== 32'd7) begin n_fail++; $display("FAIL stats_counts got %0d/%0d/%0d want 20/20/7", push_cnt, pop_cnt, stall_cnt); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++; if (push_cnt !== 32'd20 || pop_cnt !== 32'd20 || stall_cnt !== 32'd7) begin n_fail++; $display("FAIL stats_flush got %0d/%0d/%0d want 20/20/7", push_cnt, pop_cnt, stall_cnt); end
    do_reset();
    n_checks++; if (push_cnt !== 0 || pop_cnt !== 0 || stall_cnt !== 0) begin n_fail++; $display("FAIL stats_rereset got %0d/%0d/%0d want 0/0/0", push_cnt, pop_cnt, stall_cnt); end
    $display("stats counters 20/20/7 held over flush, cleared by reset");
  endtask
`endif

  initial begin
    reset = 1'b1; flush = 1'b0; val_in = 1'b0; ready_downward = 1'b0; din = '0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_full_pop();
    test_back_to_back();
    test_random();
    test_flush();
`ifdef FIFO_STREAM_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
